// File: rtl/lin_interp_upsampler_if.sv
// Sample stream handshake: a producer drives dat/valid, the consumer drives ready.
// A word moves on a rising clock edge when valid and ready are both high.
interface lin_interp_upsampler_if #(
   parameter int DW = 14
);
   logic [DW-1:0] dat;
   logic          valid;
   logic          ready;

   modport master (output dat, output valid, input ready);
   modport slave  (input dat, input valid, output ready);
endinterface

// File: rtl/lin_interp_upsampler.sv
// Linear-interpolating upsampler: takes low-rate signed samples over a valid/ready
// stream and produces one DAC word per clock. Each input sample is the end point
// of a ramp of 2**R_LOG2 outputs that starts at the previous sample. A one-entry
// buffer holds the next end point. If the buffer is empty at the end of a ramp,
// the output holds the last sample and underflow_o pulses for one cycle.
module lin_interp_upsampler #(
   parameter int DW     = 14,
   parameter int R_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   lin_interp_upsampler_if.slave in_if,
   output logic [DW-1:0]         dac_dat_o,
   output logic                  dac_vld_o,
   output logic                  underflow_o
);

   // The accumulator holds the current output scaled by 2**R_LOG2. One guard bit
   // keeps prev*R + k*step inside range for every legal end-point pair.
   localparam int AW = DW + R_LOG2 + 1;
   localparam logic [R_LOG2-1:0] P_LAST = {R_LOG2{1'b1}};

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t              r_state,   w_state;
   logic [DW-1:0]       r_x_cur,   w_x_cur;     // end point of the ramp in progress
   logic [DW-1:0]       r_nxt,     w_nxt;       // buffered next end point
   logic                r_nxt_vld, w_nxt_vld;
   logic [DW:0]         r_step,    w_step;      // x_cur - x_prev, signed
   logic [AW-1:0]       r_acc,     w_acc;       // scaled output, signed
   logic [R_LOG2-1:0]   r_phase,   w_phase;
   logic [DW-1:0]       r_dac_dat, w_dac_dat;
   logic                r_dac_vld, w_dac_vld;
   logic                r_underflow, w_underflow;

   logic                w_ready;
   logic                w_xfer;
   logic [AW-1:0]       w_step_ext;
   logic [AW-1:0]       w_cur_scaled;
   logic [AW-1:0]       w_in_scaled;

   // Accept input while idle and enabled, or while running with an empty buffer.
   // Reset forces ready low so that no transfer completes during reset.
   assign w_ready = !rst && (((r_state == ST_IDLE) && en) ||
                             ((r_state == ST_RUN) && !r_nxt_vld));
   assign w_xfer  = in_if.valid && w_ready;
   assign in_if.ready = w_ready;

   // Sign-extend the step to accumulator width, and scale samples by 2**R_LOG2.
   // An explicit sign bit and zero fill avoid relying on signed-type promotion.
   assign w_step_ext   = {{R_LOG2{r_step[DW]}}, r_step};
   assign w_cur_scaled = {r_x_cur[DW-1], r_x_cur, {R_LOG2{1'b0}}};
   assign w_in_scaled  = {in_if.dat[DW-1], in_if.dat, {R_LOG2{1'b0}}};

   // Next-state logic: ramp stepping, end-of-ramp reload and buffer handling.
   always_comb begin
      // NOTE: every w_ signal is given a default before the case statement.
      // A path that left one unassigned would infer a latch.
      w_state     = r_state;
      w_x_cur     = r_x_cur;
      w_nxt       = r_nxt;
      w_nxt_vld   = r_nxt_vld;
      w_step      = r_step;
      w_acc       = r_acc;
      w_phase     = r_phase;
      w_dac_dat   = '0;
      w_dac_vld   = 1'b0;
      w_underflow = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            // The first sample starts a flat period at its own value.
            if (w_xfer) begin
               w_x_cur = in_if.dat;
               w_step  = '0;
               w_acc   = w_in_scaled;
               w_phase = '0;
               w_state = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!en) begin
               // Dropping enable discards the buffered sample and any transfer
               // that completes on this edge.
               w_state   = ST_IDLE;
               w_nxt_vld = 1'b0;
            end else begin
               // An arithmetic shift right by R_LOG2 is a floor division.
               // The result always lies between the two end points, so the
               // DW-bit slice cannot wrap.
               w_dac_dat = r_acc[R_LOG2 +: DW];
               w_dac_vld = 1'b1;

               if (r_phase != P_LAST) begin
                  w_acc   = r_acc + w_step_ext;
                  w_phase = r_phase + R_LOG2'(1);
               end else begin
                  // End of ramp: the old end point becomes the new start.
                  w_phase = '0;
                  w_acc   = w_cur_scaled;
                  if (r_nxt_vld) begin
                     w_x_cur   = r_nxt;
                     w_step    = {r_nxt[DW-1], r_nxt} - {r_x_cur[DW-1], r_x_cur};
                     w_nxt_vld = 1'b0;
                  end else begin
                     w_step      = '0;
                     w_underflow = 1'b1;
                  end
               end

               // Ready is low while the buffer is full, so this never collides
               // with the buffer drain above.
               if (w_xfer) begin
                  w_nxt     = in_if.dat;
                  w_nxt_vld = 1'b1;
               end
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: the data registers are reset along with the control state. The
      // datapath then leaves reset at a known zero rather than holding stale
      // samples.
      if (rst) begin
         r_state     <= ST_IDLE;
         r_x_cur     <= '0;
         r_nxt       <= '0;
         r_nxt_vld   <= 1'b0;
         r_step      <= '0;
         r_acc       <= '0;
         r_phase     <= '0;
         r_dac_dat   <= '0;
         r_dac_vld   <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register update from
         // pre-edge values, regardless of statement order.
         r_state     <= w_state;
         r_x_cur     <= w_x_cur;
         r_nxt       <= w_nxt;
         r_nxt_vld   <= w_nxt_vld;
         r_step      <= w_step;
         r_acc       <= w_acc;
         r_phase     <= w_phase;
         r_dac_dat   <= w_dac_dat;
         r_dac_vld   <= w_dac_vld;
         r_underflow <= w_underflow;
      end
   end

   assign dac_dat_o   = r_dac_dat;
   assign dac_vld_o   = r_dac_vld;
   assign underflow_o = r_underflow;

endmodule

// File: tb/tb_lin_interp_upsampler.sv
// Bench for lin_interp_upsampler. A reference model works at the level of
// samples and periods: a queue holds accepted samples, and each output value
// comes from prev + floor(k*(cur-prev)/R). Each scenario task drives stimulus
// and compares the DUT against the model one cycle at a time.
module tb_lin_interp_upsampler;

   localparam int DW     = 14;
   localparam int R_LOG2 = 3;
   localparam int R      = 1 << R_LOG2;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [DW-1:0] dac_dat_o;
   logic          dac_vld_o;
   logic          underflow_o;

   lin_interp_upsampler_if #(.DW(DW)) in_if ();

   lin_interp_upsampler #(.DW(DW), .R_LOG2(R_LOG2)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .in_if       (in_if),
      .dac_dat_o   (dac_dat_o),
      .dac_vld_o   (dac_vld_o),
      .underflow_o (underflow_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] dat;
      logic          vld;
      logic          uf;
      logic          rdy;
   } obs_t;

   // Reference model state.
   bit m_run;
   int m_prev, m_cur, m_k;
   int m_q[$];

   int n_vec = 0;
   int n_err = 0;
   int feed_q[$];

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b) != 0 && a < 0) q--;
      return q;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("dat=%0d vld=%b uf=%b rdy=%b", $signed(o.dat), o.vld, o.uf, o.rdy);
   endfunction

   // One clock: capture ready before the edge, advance the model at the edge,
   // then sample the DUT outputs 1 time unit later.
   task automatic cycle(output obs_t exp, output obs_t got);
      bit xfer;
      int s;
      #1;
      exp     = '0;
      got     = '0;
      exp.rdy = !rst && ((!m_run && en) || (m_run && m_q.size() == 0));
      got.rdy = in_if.ready;
      xfer    = in_if.valid && exp.rdy;
      s       = int'($signed(in_if.dat));
      @(posedge clk);
      if (rst) begin
         m_run = 1'b0;
         m_q.delete();
      end else if (!m_run) begin
         if (xfer) begin
            m_run  = 1'b1;
            m_prev = s;
            m_cur  = s;
            m_k    = 0;
         end
      end else if (!en) begin
         m_run = 1'b0;
         m_q.delete();
      end else begin
         exp.dat = DW'(m_prev + floor_div(m_k * (m_cur - m_prev), R));
         exp.vld = 1'b1;
         if (m_k == R - 1) begin
            m_k    = 0;
            m_prev = m_cur;
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else exp.uf = 1'b1;
         end else begin
            m_k++;
         end
         if (xfer) m_q.push_back(s);
      end
      #1;
      got.dat = dac_dat_o;
      got.vld = dac_vld_o;
      got.uf  = underflow_o;
   endtask

   task automatic test_reset();
      obs_t e, g;
      rst = 1'b1; en = 1'b1; in_if.valid = 1'b1; in_if.dat = DW'(123);
      for (int i = 0; i < 3; i++) begin
         cycle(e, g); n_vec++;
         if (g !== e) begin
            n_err++; $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
      rst = 1'b0; in_if.valid = 1'b0;
      cycle(e, g); n_vec++;
      if (g !== e) begin
         n_err++; $display("FAIL reset_ready: got %s, expected %s", fmt(g), fmt(e));
      end
      en = 1'b0;
      cycle(e, g); n_vec++;
      if (g !== e) begin
         n_err++; $display("FAIL reset_idle: got %s, expected %s", fmt(g), fmt(e));
      end
   endtask

   // Feed feed_q as fast as the DUT accepts, then stall. Ends by returning to IDLE.
   task automatic test_sequence(input string name, input int ncyc);
      obs_t e, g;
      en = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         in_if.valid = (feed_q.size() > 0);
         in_if.dat   = (feed_q.size() > 0) ? DW'(feed_q[0]) : '0;
         cycle(e, g); n_vec++;
         if (g !== e) begin
            n_err++; $display("FAIL %s[%0d]: got %s, expected %s", name, i, fmt(g), fmt(e));
         end
         if (in_if.valid && e.rdy) void'(feed_q.pop_front());
      end
      en = 1'b0; in_if.valid = 1'b0;
      cycle(e, g); n_vec++;
      if (g !== e) begin
         n_err++; $display("FAIL %s_stop: got %s, expected %s", name, fmt(g), fmt(e));
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, g;
      int uf_seen = 0;
      en = 1'b1; in_if.valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         in_if.dat = DW'($urandom);
         cycle(e, g); n_vec++;
         if (g !== e) begin
            n_err++; $display("FAIL stream[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
         if (g.uf === 1'b1) uf_seen++;
      end
      n_vec++;
      if (uf_seen !== 0) begin
         n_err++; $display("FAIL stream_no_underflow: got %0d pulses, expected 0", uf_seen);
      end
      en = 1'b0; in_if.valid = 1'b0;
      cycle(e, g); n_vec++;
      if (g !== e) begin
         n_err++; $display("FAIL stream_stop: got %s, expected %s", fmt(g), fmt(e));
      end
   endtask

   task automatic test_gap();
      obs_t e, g;
      en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_if.valid = (i >= 100 && i < 130) ? 1'b0 : ($urandom_range(0, 3) == 0);
         in_if.dat   = DW'($urandom);
         cycle(e, g); n_vec++;
         if (g !== e) begin
            n_err++; $display("FAIL gap[%0d]: got %s, expected %s", i, fmt(g), fmt(e));
         end
      end
      en = 1'b0; in_if.valid = 1'b0;
      cycle(e, g); n_vec++;
      if (g !== e) begin
         n_err++; $display("FAIL gap_stop: got %s, expected %s", fmt(g), fmt(e));
      end
   endtask

   // Interrupt a running stream, either by reset or by dropping enable, at
   // several points, then keep feeding so the restart latency is checked.
   task automatic test_interrupt(input bit use_rst, input int drop_at);
      obs_t e, g;
      en = 1'b1; in_if.valid = 1'b1;
      for (int i = 0; i < drop_at + 24; i++) begin
         in_if.dat = DW'($urandom);
         if (i == drop_at) begin
            if (use_rst) rst = 1'b1;
            else en = 1'b0;
         end else begin
            rst = 1'b0; en = 1'b1;
         end
         cycle(e, g); n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL %s@%0d[%0d]: got %s, expected %s", use_rst ? "rst" : "en_drop",
                     drop_at, i, fmt(g), fmt(e));
         end
      end
      rst = 1'b0; en = 1'b0; in_if.valid = 1'b0;
      cycle(e, g); n_vec++;
      if (g !== e) begin
         n_err++; $display("FAIL interrupt_stop: got %s, expected %s", fmt(g), fmt(e));
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_if.valid = 1'b0; in_if.dat = '0;
      m_run = 1'b0; m_prev = 0; m_cur = 0; m_k = 0;

      test_reset();

      feed_q = '{0, 800};
      test_sequence("ramp", 40);
      feed_q = '{0, -4};
      test_sequence("floor", 24);
      feed_q = '{-8192, 8191, -8192};
      test_sequence("extremes", 40);

      test_back_to_back();
      test_gap();

      foreach (feed_q[i]) feed_q.delete(i);
      for (int d = 5; d < 20; d += 4) begin
         test_interrupt(1'b1, d);
         test_interrupt(1'b0, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
